imem_arbiter: RTL and testbench

- Shares the single-port instruction memory between two requesters: the CPU fetch stage (read-only) and the boot/debug loader (read/write).
- Provides request/grant arbitration, a boot phase that blocks fetch until the loader releases the core, and loader bus locking for bursts.
- Checks alignment and range, and routes the 1-cycle read data back to the owning requester.
- Sits between the CPU front end, the loader, and the memory array.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_rr_arb2.sv | 42 ++++
 rtl/imem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_imem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
//   NOP_INSN    : instruction returned to fetch on an error response.
//   owner_e     : which requester owns the response in flight.
//   arb_state_e : arbiter phase (boot, normal run, loader lock).
//   addr_err()  : misaligned or out-of-range byte address check.
package imem_pkg;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    LD   = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } arb_state_e;

  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] size);
    return (addr[1:0] != 2'b00) || (addr >= size);
  endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-input round-robin arbiter with a per-requester enable mask.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i[1:0]   : requests (bit 0 = fetch, bit 1 = loader)
//   mask_i[1:0]  : per-requester enable; a masked request is never granted
//   gnt_o[1:0]   : one-hot (or zero) grant, combinational
// The last winner is remembered; on contention the other requester wins.
// After reset the loader counts as last winner, so fetch wins the first tie.
module imem_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic       last_ld_q;
  logic       last_ld_d;
  logic [1:0] req_m;

  always_comb begin
    req_m = req_i & mask_i;
    gnt_o = req_m;
    if (req_m == 2'b11) begin
      gnt_o = last_ld_q ? 2'b01 : 2'b10;
    end
    last_ld_d = last_ld_q;
    if (gnt_o[1]) begin
      last_ld_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_ld_q <= 1'b1;
    end else begin
      last_ld_q <= last_ld_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between CPU fetch (read-only) and
// the boot/debug loader (read/write).
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_boot_release        : pulse that ends the boot phase (fetch blocked in boot)
//   i_if_*  / o_if_*      : fetch request/grant and 1-cycle response
//   i_ld_*  / o_ld_*      : loader request/grant (with bus lock) and response
//   o_mem_*, i_mem_rdata  : memory array port, read data one cycle after enable
// Optional build macro IMEM_ARB_STATS_EN adds o_stat_conflicts (contended
// cycles) and o_stat_errs (error responses), both saturating.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int SIZE = 512,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_boot_release,
  input  logic          i_if_req,
  input  logic [31:0]   i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_err,
  input  logic          i_ld_req,
  input  logic          i_ld_we,
  input  logic          i_ld_lock,
  input  logic [31:0]   i_ld_addr,
  input  logic [31:0]   i_ld_wdata,
  input  logic [3:0]    i_ld_be,
  output logic          o_ld_gnt,
  output logic          o_ld_rvalid,
  output logic [31:0]   o_ld_rdata,
  output logic          o_ld_err,
  output logic          o_mem_en,
  output logic [3:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]   o_stat_conflicts,
  output logic [15:0]   o_stat_errs
`endif
);

  arb_state_e state_q, state_d;
  owner_e     resp_owner_q, resp_owner_d;
  logic       resp_err_q, resp_err_d;
  logic       resp_wr_q, resp_wr_d;

  logic [1:0] req;
  logic [1:0] mask;
  logic [1:0] gnt;
  logic       if_err;
  logic       ld_err;

  // Grants are suppressed while reset is held so every output reads 0.
  assign req  = {i_ld_req, i_if_req};
  assign mask = {!i_rst, !i_rst && (state_q == RUN)};

  imem_rr_arb2 u_arb (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .req_i  (req),
    .mask_i (mask),
    .gnt_o  (gnt)
  );

  assign o_if_gnt = gnt[0];
  assign o_ld_gnt = gnt[1];
  assign if_err   = addr_err(i_if_addr, 32'(SIZE));
  assign ld_err   = addr_err(i_ld_addr, 32'(SIZE));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a locked loader grant coinciding with boot release
  // goes straight to LOCK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: if (i_boot_release) state_d = (gnt[1] && i_ld_lock) ? LOCK : RUN;
      RUN:  if (gnt[1] && i_ld_lock) state_d = LOCK;
      LOCK: if ((gnt[1] && !i_ld_lock) || (!i_ld_req && !i_ld_lock)) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Memory drive in the grant cycle; erroneous accesses are granted but
  // never reach the array.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = 32'h0;
    if (gnt[1]) begin
      o_mem_en    = !ld_err;
      o_mem_addr  = i_ld_addr[AW-1:0];
      o_mem_be    = (i_ld_we && !ld_err) ? i_ld_be : 4'b0000;
      o_mem_wdata = i_ld_wdata;
    end else if (gnt[0]) begin
      o_mem_en    = !if_err;
      o_mem_addr  = i_if_addr[AW-1:0];
      o_mem_wdata = i_ld_wdata;
    end
  end

  // Response tracking: one entry, owner of the access granted last cycle.
  always_comb begin
    resp_owner_d = gnt[1] ? LD : (gnt[0] ? IF : NONE);
    resp_err_d   = gnt[1] ? ld_err : if_err;
    resp_wr_d    = gnt[1] && i_ld_we;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resp_owner_q <= NONE;
      resp_err_q   <= 1'b0;
      resp_wr_q    <= 1'b0;
    end else begin
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
      resp_wr_q    <= resp_wr_d;
    end
  end

  always_comb begin
    o_if_rvalid = 1'b0;
    o_if_err    = 1'b0;
    o_if_rdata  = 32'h0;
    o_ld_rvalid = 1'b0;
    o_ld_err    = 1'b0;
    o_ld_rdata  = 32'h0;
    case (resp_owner_q)
      IF: begin
        o_if_rvalid = 1'b1;
        o_if_err    = resp_err_q;
        o_if_rdata  = resp_err_q ? NOP_INSN : i_mem_rdata;
      end
      LD: begin
        o_ld_rvalid = 1'b1;
        o_ld_err    = resp_err_q;
        o_ld_rdata  = (resp_err_q || resp_wr_q) ? 32'h0 : i_mem_rdata;
      end
      default: ;
    endcase
  end

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] conflicts_q;
  logic [15:0] errs_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      conflicts_q <= 32'h0;
      errs_q      <= 16'h0;
    end else begin
      // Both requesting always means exactly one is denied.
      if (i_if_req && i_ld_req && (conflicts_q != 32'hFFFF_FFFF)) begin
        conflicts_q <= conflicts_q + 32'd1;
      end
      if ((resp_owner_q != NONE) && resp_err_q && (errs_q != 16'hFFFF)) begin
        errs_q <= errs_q + 16'd1;
      end
    end
  end

  assign o_stat_conflicts = conflicts_q;
  assign o_stat_errs      = errs_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: stimulus tasks record expected
// responses in a queue at grant time; the following cycle pops and compares.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_release;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ld_req, ld_we, ld_lock;
  logic [31:0] ld_addr, ld_wdata;
  logic [3:0]  ld_be;
  logic        ld_gnt, ld_rvalid, ld_err;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.SIZE(512)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_boot_release (boot_release),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_gnt       (if_gnt),
    .o_if_rvalid    (if_rvalid),
    .o_if_rdata     (if_rdata),
    .o_if_err       (if_err),
    .i_ld_req       (ld_req),
    .i_ld_we        (ld_we),
    .i_ld_lock      (ld_lock),
    .i_ld_addr      (ld_addr),
    .i_ld_wdata     (ld_wdata),
    .i_ld_be        (ld_be),
    .o_ld_gnt       (ld_gnt),
    .o_ld_rvalid    (ld_rvalid),
    .o_ld_rdata     (ld_rdata),
    .o_ld_err       (ld_err),
    .o_mem_en       (mem_en),
    .o_mem_be       (mem_be),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  // Memory array model driven by the DUT memory port.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem[mem_addr[8:2]];
    end
  end

  // Reference contents, updated from the stimulus side only.
  logic [31:0] refmem [0:127];

  typedef struct {
    logic        own_ld;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic logic a_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd512);
  endfunction

  // One clock: check last cycle's response and this cycle's grant.
  task automatic step(input logic eif, input logic eld, input string tag);
    resp_t       r;
    logic [31:0] a;
    logic        e;
    logic [3:0]  ebe;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      tests++;
      if (if_rvalid !== !r.own_ld || ld_rvalid !== r.own_ld) begin
        fails++;
        $display("FAIL %s rvalid: got if=%0b ld=%0b, want owner_ld=%0b", tag, if_rvalid, ld_rvalid, r.own_ld);
      end
      tests++;
      if (r.own_ld) begin
        if (ld_err !== r.err || ld_rdata !== r.rdata) begin
          fails++;
          $display("FAIL %s ld resp: got err=%0b data=%h, want err=%0b data=%h", tag, ld_err, ld_rdata, r.err, r.rdata);
        end
      end else begin
        if (if_err !== r.err || if_rdata !== r.rdata) begin
          fails++;
          $display("FAIL %s if resp: got err=%0b data=%h, want err=%0b data=%h", tag, if_err, if_rdata, r.err, r.rdata);
        end
      end
    end else begin
      tests++;
      if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL %s idle rvalid: got if=%0b ld=%0b, want 0 0", tag, if_rvalid, ld_rvalid);
      end
    end
    tests++;
    if (if_gnt !== eif || ld_gnt !== eld) begin
      fails++;
      $display("FAIL %s gnt: got if=%0b ld=%0b, want if=%0b ld=%0b", tag, if_gnt, ld_gnt, eif, eld);
    end
    if (eif || eld) begin
      a = eld ? ld_addr : if_addr;
      e = a_err(a);
      r.own_ld = eld;
      r.err    = e;
      if (eld) r.rdata = (e || ld_we) ? 32'h0 : refmem[a[8:2]];
      else     r.rdata = e ? 32'h00000013 : refmem[a[8:2]];
      ebe = (eld && ld_we && !e) ? ld_be : 4'b0000;
      tests++;
      if (mem_en !== !e || mem_be !== ebe || (!e && mem_addr !== a[8:0])) begin
        fails++;
        $display("FAIL %s mem: got en=%0b be=%h addr=%h, want en=%0b be=%h addr=%h", tag, mem_en, mem_be, mem_addr, !e, ebe, a[8:0]);
      end
      if (eld && ld_we && !e) begin
        for (int b = 0; b < 4; b++) begin
          if (ld_be[b]) refmem[a[8:2]][8*b +: 8] = ld_wdata[8*b +: 8];
        end
      end
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d; ld_be = be;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err, mem_en} !== 7'b0) begin
      fails++;
      $display("FAIL reset ctrl: got %b, want 0000000", {if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err, mem_en});
    end
    tests++;
    if (if_rdata !== 32'h0 || ld_rdata !== 32'h0 || mem_be !== 4'h0) begin
      fails++;
      $display("FAIL reset data: got if=%h ld=%h be=%h, want 0", if_rdata, ld_rdata, mem_be);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_boot_load();
    if_req = 1'b1; if_addr = 32'h10;
    ld_write(32'h10, 32'hDEADBEEF, 4'hF);   step(1'b0, 1'b1, "boot_wr10");
    ld_write(32'h14, 32'h12345678, 4'hF);   step(1'b0, 1'b1, "boot_wr14");
    ld_write(32'h18, 32'hCAFEF00D, 4'hF);   step(1'b0, 1'b1, "boot_wr18");
    ld_write(32'h1C, 32'hAAAABEEF, 4'b0011); step(1'b0, 1'b1, "boot_wr1c_be");
    ld_req = 1'b0; ld_we = 1'b0;
    step(1'b0, 1'b0, "boot_if_held");
    step(1'b0, 1'b0, "boot_if_held2");
  endtask

  task automatic test_boot_release();
    boot_release = 1'b1;
    step(1'b0, 1'b0, "release_cycle");
    boot_release = 1'b0;
    step(1'b1, 1'b0, "run_fetch10");
    if_req = 1'b0;
    step(1'b0, 1'b0, "run_drain");
  endtask

  task automatic test_round_robin();
    int ii = 0;
    int li = 0;
    logic eld;
    if_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if_addr = 32'h10 + 32'(4 * (ii % 4));
      ld_addr = 32'h1C - 32'(4 * (li % 4));
      eld = (c % 2 == 0);
      step(!eld, eld, "rr");
      if (eld) li++; else ii++;
    end
    if_req = 1'b0; ld_req = 1'b0;
    step(1'b0, 1'b0, "rr_drain");
  endtask

  task automatic test_errors();
    if_req = 1'b1;
    if_addr = 32'h2;   step(1'b1, 1'b0, "if_misalign");
    if_addr = 32'h200; step(1'b1, 1'b0, "if_range");
    if_req = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h201;
    step(1'b0, 1'b1, "ld_rd_err");
    ld_write(32'h13, 32'h55555555, 4'hF);
    step(1'b0, 1'b1, "ld_wr_err");
    ld_we = 1'b0; ld_addr = 32'h10;
    step(1'b0, 1'b1, "ld_rd_after_err");
    ld_req = 1'b0;
    step(1'b0, 1'b0, "err_drain");
  endtask

  task automatic test_lock();
    if_req = 1'b1; if_addr = 32'h14;
    step(1'b1, 1'b0, "lock_pre_fetch");
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b0;
    ld_addr = 32'h10; step(1'b0, 1'b1, "lock_g1");
    ld_addr = 32'h14; step(1'b0, 1'b1, "lock_g2");
    ld_addr = 32'h18; step(1'b0, 1'b1, "lock_g3");
    ld_req = 1'b0; ld_lock = 1'b0;
    step(1'b0, 1'b0, "lock_drop");
    step(1'b1, 1'b0, "lock_after");
    if_req = 1'b0;
    step(1'b0, 1'b0, "lock_drain");
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h10;
    step(1'b1, 1'b0, "pre_reset_fetch");
    rst = 1'b1;
    exp_q.delete();
    step(1'b0, 1'b0, "in_reset");
    rst = 1'b0;
    step(1'b0, 1'b0, "post_reset_boot");
    // Release together with a locked loader grant must land in LOCK.
    boot_release = 1'b1; ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
    step(1'b0, 1'b1, "release_with_lock");
    boot_release = 1'b0; ld_req = 1'b0;
    step(1'b0, 1'b0, "locked_idle");
    ld_lock = 1'b0;
    step(1'b0, 1'b0, "unlock");
    step(1'b1, 1'b0, "run_after_unlock");
    if_req = 1'b0;
    step(1'b0, 1'b0, "final_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'h0;
      refmem[i] = 32'h0;
    end
    mem_rdata = 32'h0;
    rst = 1'b1; boot_release = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0;
    ld_addr = 32'h0; ld_wdata = 32'h0; ld_be = 4'h0;
    test_reset();
    test_boot_load();
    test_boot_release();
    test_round_robin();
    test_errors();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
